wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter p_starve_limit, default 4: consecutive blocked cycles of the B-queue head before port A is held off for one cycle (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports a_val input 1, a_rdy output 1, a_addr input 5, a_data input 32: single-cycle pipeline writeback, port A.
REQ-005 SHALL have ports b_val input 1, b_rdy output 1, b_addr input 5, b_data input 32: long-latency unit writeback, port B.
REQ-006 SHALL have ports sb_set_en input 1, sb_set_addr input 5: marks a destination register pending when port B work is issued.
REQ-007 SHALL have output pending, 32 bits, one bit per register, registered.
REQ-008 SHALL have outputs wr_en 1, wr_addr 5, wr_data 32, driving the write port of the r0-zero 2r1w register file.

Function
REQ-009 SHALL buffer port B in a 2-entry FIFO; b_rdy = FIFO not full, or full with its head being written this cycle.
REQ-010 SHALL enqueue B on b_val && b_rdy at the clock edge; an enqueued entry is written no earlier than the next cycle (minimum latency 1).
REQ-011 SHALL write port A combinationally in the same cycle when a_val && a_rdy: wr_addr = a_addr, wr_data = a_data.
REQ-012 SHALL give port A priority: the FIFO head is written only in cycles where no A transfer occurs.
REQ-013 SHALL keep a saturating counter of consecutive cycles in which the FIFO is non-empty and its head is not written; a_rdy = 0 for exactly one cycle when the counter equals p_starve_limit, and the head is written in that cycle.
REQ-014 SHALL hold a_rdy = 1 in every other cycle, including reset.
REQ-015 SHALL clear the starvation counter on any cycle in which the head is written or the FIFO is empty.
REQ-016 SHALL pop the FIFO head on the edge following the cycle it is written; simultaneous push and pop on a full FIFO is legal and leaves occupancy at 2.
REQ-017 SHALL assert wr_en only for a transfer with a nonzero address; a transfer to x0 is consumed (handshake completes, FIFO pops) with wr_en = 0.
REQ-018 SHALL drive wr_en = 0 when no transfer occurs; wr_addr and wr_data are don't-care when wr_en = 0.
REQ-019 SHALL set pending[sb_set_addr] on the edge after sb_set_en, except for address 0.
REQ-020 SHALL clear pending[head address] on the edge after the FIFO head is written.
REQ-021 SHALL let set win when set and clear target the same register in the same cycle.
REQ-022 SHALL hold pending[0] at 0 in all cycles.
REQ-023 SHALL preserve FIFO order; B writes leave in enqueue order.

Reset
REQ-024 SHALL, while reset is high, empty the FIFO, zero the starvation counter, and clear pending to 32'h0, with wr_en = 0 and b_rdy = 0.
REQ-025 SHALL discard any buffered B entries when reset is asserted mid-operation, with no write issued in the reset cycle.
REQ-026 SHALL set a_rdy = 1 and b_rdy = 1 on the first cycle after reset deasserts.

Verification
REQ-027 SHALL pass this case: A write x5=32'hDEADBEEF with B idle -> same cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
REQ-028 SHALL pass this case: sb_set x7; B enq x7=32'h1 at cycle n; A idle -> pending[7]=1 at n+1, wr_en=1 to x7 at n+1, pending[7]=0 at n+2.
REQ-029 SHALL pass this case: B enq x3 and then x4; A valid every cycle -> b_rdy=0 once 2 entries are held; after 4 blocked cycles a_rdy=0 for one cycle and x3 is written; 4 cycles later x4 is written the same way.
REQ-030 SHALL pass this case: B enq x0=32'hFF -> entry pops the next cycle with wr_en=0; sb_set x0 -> pending stays 32'h0.
REQ-031 SHALL pass this case: set and clear of x9 in the same cycle -> pending[9]=1 afterwards.
REQ-032 SHALL pass this case: reset asserted with 2 B entries buffered -> FIFO empty and pending=0 after that edge, and no stale write appears after reset deasserts.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of the two writeback ports, scoreboard set port, pending vector and
// register-file write port seen by wb_arbiter.
interface wb_arbiter_if;
  logic        a_val;
  logic        a_rdy;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_val;
  logic        b_rdy;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic [31:0] pending;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  a_val, a_addr, a_data, b_val, b_addr, b_data, sb_set_en, sb_set_addr,
    output a_rdy, b_rdy, pending, wr_en, wr_addr, wr_data
  );

  modport master (
    output a_val, a_addr, a_data, b_val, b_addr, b_data, sb_set_en, sb_set_addr,
    input  a_rdy, b_rdy, pending, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: port A (pipeline) has priority, port B
// (long-latency) is queued in a 2-entry FIFO with starvation relief; tracks pending regs.
module wb_arbiter #(
  parameter int unsigned p_starve_limit = 4
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam logic [3:0] c_starve_limit = 4'(p_starve_limit);

  logic [4:0]  fifo_addr [2];
  logic [31:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;
  logic [3:0]  starve_cnt;
  logic [31:0] pending_q;
  logic [31:0] pending_nxt;

  logic        fifo_empty;
  logic        fifo_full;
  logic        starve;
  logic        a_rdy_int;
  logic        b_rdy_int;
  logic        a_xfer;
  logic        head_wr;
  logic        push;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign fifo_full  = (fifo_cnt == 2'd2);
  assign head_addr  = fifo_addr[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // Holding A off for one cycle guarantees the starved head a slot.
  assign starve    = !fifo_empty && (starve_cnt == c_starve_limit);
  assign a_rdy_int = !starve;
  assign a_xfer    = !reset && bus.a_val && a_rdy_int;
  assign head_wr   = !reset && !fifo_empty && !a_xfer;
  assign b_rdy_int = !reset && (!fifo_full || head_wr);
  assign push      = bus.b_val && b_rdy_int;

  assign bus.a_rdy   = a_rdy_int;
  assign bus.b_rdy   = b_rdy_int;
  assign bus.pending = pending_q;

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = bus.a_addr;
    bus.wr_data = bus.a_data;
    if (a_xfer) begin
      bus.wr_en = (bus.a_addr != 5'd0);
    end else if (head_wr) begin
      bus.wr_en   = (head_addr != 5'd0);
      bus.wr_addr = head_addr;
      bus.wr_data = head_data;
    end
  end

  // Set is applied after clear so a same-cycle set of the same register wins.
  always_comb begin
    pending_nxt = pending_q;
    if (head_wr) pending_nxt[head_addr] = 1'b0;
    if (bus.sb_set_en) pending_nxt[bus.sb_set_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.b_addr;
      fifo_data[wr_ptr] <= bus.b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      starve_cnt <= 4'd0;
      pending_q  <= 32'h0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (head_wr) rd_ptr <= ~rd_ptr;
      case ({push, head_wr})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (fifo_empty || head_wr) starve_cnt <= 4'd0;
      else if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
      pending_q <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter; inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  wb_arbiter_if bus ();

  wb_arbiter #(.p_starve_limit(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_val       = 1'b0;
    bus.a_addr      = 5'd0;
    bus.a_data      = 32'h0;
    bus.b_val       = 1'b0;
    bus.b_addr      = 5'd0;
    bus.b_data      = 32'h0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = 5'd0;
  endtask

  task automatic drive_b(input logic [4:0] addr, input logic [31:0] data);
    bus.b_val  = 1'b1;
    bus.b_addr = addr;
    bus.b_data = data;
  endtask

  task automatic drive_a(input logic [4:0] addr, input logic [31:0] data);
    bus.a_val  = 1'b1;
    bus.a_addr = addr;
    bus.a_data = data;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    next_cyc();
    drive_a(5'd2, 32'h1234);
    @(negedge clk);
    check_val("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("rst_b_rdy", 32'(bus.b_rdy), 32'd0);
    check_val("rst_a_rdy", 32'(bus.a_rdy), 32'd1);
    check_val("rst_pending", bus.pending, 32'h0);
    next_cyc();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check_val("post_rst_a_rdy", 32'(bus.a_rdy), 32'd1);
    check_val("post_rst_b_rdy", 32'(bus.b_rdy), 32'd1);
    check_val("post_rst_wr_en", 32'(bus.wr_en), 32'd0);

    // A write, B idle
    next_cyc();
    drive_a(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check_val("a_wr_en", 32'(bus.wr_en), 32'd1);
    check_val("a_wr_addr", 32'(bus.wr_addr), 32'd5);
    check_val("a_wr_data", bus.wr_data, 32'hDEADBEEF);

    // B enqueue with scoreboard set, A idle
    next_cyc();
    idle();
    drive_b(5'd7, 32'h1);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd7;
    @(negedge clk);
    check_val("b_enq_wr_en", 32'(bus.wr_en), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check_val("b_pend7_set", 32'(bus.pending[7]), 32'd1);
    check_val("b_wr_en", 32'(bus.wr_en), 32'd1);
    check_val("b_wr_addr", 32'(bus.wr_addr), 32'd7);
    check_val("b_wr_data", bus.wr_data, 32'h1);
    next_cyc();
    @(negedge clk);
    check_val("b_pend7_clr", 32'(bus.pending[7]), 32'd0);
    check_val("b_done_wr_en", 32'(bus.wr_en), 32'd0);

    // Starvation: A valid every cycle, B holds x3 then x4; x6 pushed while full
    next_cyc();
    drive_a(5'd1, 32'd0);
    drive_b(5'd3, 32'h33);
    @(negedge clk);
    check_val("st0_wr_addr", 32'(bus.wr_addr), 32'd1);
    next_cyc();
    drive_a(5'd1, 32'd1);
    drive_b(5'd4, 32'h44);
    @(negedge clk);
    check_val("st1_b_rdy", 32'(bus.b_rdy), 32'd1);
    check_val("st1_a_rdy", 32'(bus.a_rdy), 32'd1);
    for (int k = 2; k <= 16; k++) begin
      next_cyc();
      idle();
      drive_a(5'd1, 32'(k));
      if (k == 5) drive_b(5'd6, 32'h66);
      @(negedge clk);
      case (k)
        5:       begin e_addr = 5'd3; e_data = 32'h33; end
        10:      begin e_addr = 5'd4; e_data = 32'h44; end
        15:      begin e_addr = 5'd6; e_data = 32'h66; end
        default: begin e_addr = 5'd1; e_data = 32'(k); end
      endcase
      check_val($sformatf("st%0d_a_rdy", k), 32'(bus.a_rdy), 32'((k != 5) && (k != 10) && (k != 15)));
      check_val($sformatf("st%0d_b_rdy", k), 32'(bus.b_rdy), 32'((k == 5) || (k >= 10)));
      check_val($sformatf("st%0d_wr_en", k), 32'(bus.wr_en), 32'd1);
      check_val($sformatf("st%0d_wr_addr", k), 32'(bus.wr_addr), 32'(e_addr));
      check_val($sformatf("st%0d_wr_data", k), bus.wr_data, e_data);
    end

    // B write to x0 and scoreboard set of x0
    next_cyc();
    idle();
    drive_b(5'd0, 32'hFF);
    bus.sb_set_en = 1'b1;
    @(negedge clk);
    check_val("x0_enq_wr_en", 32'(bus.wr_en), 32'd0);
    next_cyc();
    idle();
    @(negedge clk);
    check_val("x0_pop_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("x0_pending", bus.pending, 32'h0);

    // Same-cycle set and clear of x9
    next_cyc();
    drive_b(5'd9, 32'h9);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd9;
    next_cyc();
    idle();
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd9;
    @(negedge clk);
    check_val("x9_pend_before", bus.pending, 32'h200);
    check_val("x9_wr_en", 32'(bus.wr_en), 32'd1);
    check_val("x9_wr_addr", 32'(bus.wr_addr), 32'd9);
    next_cyc();
    idle();
    @(negedge clk);
    check_val("x9_set_wins", bus.pending, 32'h200);
    drive_b(5'd9, 32'h99);
    next_cyc();
    idle();
    next_cyc();
    @(negedge clk);
    check_val("x9_cleared", bus.pending, 32'h0);

    // Reset with two buffered B entries
    next_cyc();
    drive_a(5'd1, 32'hA);
    drive_b(5'd11, 32'hB11);
    next_cyc();
    drive_b(5'd12, 32'hB12);
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd11;
    next_cyc();
    idle();
    drive_a(5'd1, 32'hA);
    reset = 1'b1;
    @(negedge clk);
    check_val("mid_rst_pending", bus.pending, 32'h800);
    check_val("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
    check_val("mid_rst_b_rdy", 32'(bus.b_rdy), 32'd0);
    check_val("mid_rst_a_rdy", 32'(bus.a_rdy), 32'd1);
    next_cyc();
    reset = 1'b0;
    idle();
    @(negedge clk);
    check_val("after_rst_pending", bus.pending, 32'h0);
    check_val("after_rst_b_rdy", 32'(bus.b_rdy), 32'd1);
    check_val("after_rst_a_rdy", 32'(bus.a_rdy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val($sformatf("no_stale_wr_%0d", k), 32'(bus.wr_en), 32'd0);
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
